// File: rtl/frequency_scan_controller.sv
// Scan-line sequencer: turns a binarized pixel stream into run lengths, runs the pattern
// recognizer on them and returns its jump index. Optional merge filter: FREQ_SCAN_MIN_RUN_FILTER_EN.
module frequency_scan_controller #(
    parameter int DATA_WIDTH       = 8,
    parameter int SAMPLES_QUANTITY = 25,
    parameter int TIMEOUT_CYCLES   = 1024,
    parameter int MIN_RUN_LENGTH   = 2
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   line_start,
    input  logic                                   pixel_valid,
    input  logic                                   pixel_value,
    input  logic                                   pixel_last,
    output logic                                   pixel_ready,
    output logic [DATA_WIDTH*SAMPLES_QUANTITY-1:0] samples,
    output logic                                   recognizer_reset,
    input  logic                                   recognizer_completed,
    input  logic [DATA_WIDTH-1:0]                  recognizer_index,
    output logic                                   result_valid,
    input  logic                                   result_ready,
    output logic [DATA_WIDTH-1:0]                  result_index,
    output logic                                   result_overflow,
    output logic                                   result_timeout,
    output logic                                   busy
);
    localparam int IDX_W = $clog2(SAMPLES_QUANTITY + 1);
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) > 0) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [DATA_WIDTH-1:0] RUN_MAX  = '1;
    localparam logic [DATA_WIDTH-1:0] MIN_RUN  = DATA_WIDTH'(MIN_RUN_LENGTH);
    localparam logic [IDX_W-1:0]      SLOT_END = IDX_W'(SAMPLES_QUANTITY);
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

`ifdef FREQ_SCAN_MIN_RUN_FILTER_EN
    localparam bit FILTER_EN = 1'b1;
`else
    localparam bit FILTER_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_FLUSH,
        S_RECOGNIZE,
        S_DONE
    } state_t;

    state_t                state_reg, state_next;
    logic [IDX_W-1:0]      slot_index_reg, slot_index_next;
    logic [DATA_WIDTH-1:0] run_length_reg, run_length_next;
    logic                  colour_reg, colour_next;
    logic                  overflow_reg, overflow_next;
    logic                  timeout_reg, timeout_next;
    logic [DATA_WIDTH-1:0] index_reg, index_next;
    logic [CNT_W-1:0]      count_reg, count_next;

    logic                  accept;
    logic                  close_run;
    logic                  merge_run;
    logic                  store_run;
    logic                  drop_run;
    logic                  clear_slots;
    logic                  slot_we;
    logic [IDX_W-1:0]      slot_addr;
    logic [IDX_W-1:0]      last_addr;
    logic [DATA_WIDTH-1:0] slot_data;
    logic [DATA_WIDTH-1:0] last_slot;
    logic [DATA_WIDTH:0]   merge_sum;

    // ---------------- state register and control decode ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        pixel_ready      = 1'b0;
        recognizer_reset = 1'b1;
        result_valid     = 1'b0;
        busy             = 1'b1;
        case (state_reg)
            S_IDLE: begin
                busy = 1'b0;
                if (line_start) begin
                    state_next = S_COLLECT;
                end
            end
            S_COLLECT: begin
                pixel_ready = 1'b1;
                if (accept && pixel_last) begin
                    state_next = S_FLUSH;
                end
            end
            S_FLUSH: begin
                state_next = S_RECOGNIZE;
            end
            S_RECOGNIZE: begin
                recognizer_reset = 1'b0;
                if (recognizer_completed || (count_reg == CNT_LAST)) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                result_valid = 1'b1;
                if (result_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // ---------------- run closing and slot write selection ----------------
    assign accept    = pixel_valid && (state_reg == S_COLLECT);
    // A run closes on a colour change, or unconditionally in FLUSH (the line's final run).
    assign close_run = (state_reg == S_FLUSH) ||
                       (accept && (run_length_reg != '0) && (pixel_value != colour_reg));
    assign merge_run = FILTER_EN && close_run && (run_length_reg < MIN_RUN) &&
                       (slot_index_reg != '0);
    assign store_run = close_run && !merge_run && (slot_index_reg < SLOT_END);
    assign drop_run  = close_run && !merge_run && (slot_index_reg == SLOT_END);
    assign last_addr = slot_index_reg - IDX_W'(1);

    always_comb begin
        last_slot = '0;
        for (int i = 0; i < SAMPLES_QUANTITY; i++) begin
            if (last_addr == IDX_W'(i)) begin
                last_slot = samples[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign merge_sum = {1'b0, last_slot} + {1'b0, run_length_reg};
    assign slot_we   = store_run || merge_run;
    assign slot_addr = merge_run ? last_addr : slot_index_reg;
    assign slot_data = !merge_run ? run_length_reg :
                       (merge_sum[DATA_WIDTH] ? RUN_MAX : merge_sum[DATA_WIDTH-1:0]);

    // ---------------- datapath next-state ----------------
    always_comb begin
        slot_index_next = slot_index_reg;
        run_length_next = run_length_reg;
        colour_next     = colour_reg;
        overflow_next   = overflow_reg;
        timeout_next    = timeout_reg;
        index_next      = index_reg;
        count_next      = count_reg;
        clear_slots     = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (line_start) begin
                    clear_slots     = 1'b1;
                    slot_index_next = '0;
                    run_length_next = '0;
                    colour_next     = 1'b0;
                    overflow_next   = 1'b0;
                    timeout_next    = 1'b0;
                    index_next      = '0;
                end
            end
            S_COLLECT: begin
                if (accept) begin
                    if ((run_length_reg == '0) || (pixel_value != colour_reg)) begin
                        run_length_next = DATA_WIDTH'(1);
                        colour_next     = pixel_value;
                    end else if (run_length_reg != RUN_MAX) begin
                        run_length_next = run_length_reg + DATA_WIDTH'(1);
                    end
                end
            end
            S_FLUSH: begin
                count_next = '0;
            end
            S_RECOGNIZE: begin
                if (recognizer_completed) begin
                    index_next = recognizer_index;
                end else if (count_reg == CNT_LAST) begin
                    index_next   = '1;
                    timeout_next = 1'b1;
                end else begin
                    count_next = count_reg + CNT_W'(1);
                end
            end
            default: begin
            end
        endcase
        if (store_run) begin
            slot_index_next = slot_index_reg + IDX_W'(1);
        end
        if (drop_run) begin
            overflow_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_index_reg <= '0;
            run_length_reg <= '0;
            colour_reg     <= 1'b0;
            overflow_reg   <= 1'b0;
            timeout_reg    <= 1'b0;
            index_reg      <= '0;
            count_reg      <= '0;
        end else begin
            slot_index_reg <= slot_index_next;
            run_length_reg <= run_length_next;
            colour_reg     <= colour_next;
            overflow_reg   <= overflow_next;
            timeout_reg    <= timeout_next;
            index_reg      <= index_next;
            count_reg      <= count_next;
        end
    end

    // ---------------- sample slots, presented in parallel ----------------
    generate
        for (genvar gi = 0; gi < SAMPLES_QUANTITY; gi++) begin : g_slot
            logic [DATA_WIDTH-1:0] slot_reg;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    slot_reg <= '0;
                end else if (clear_slots) begin
                    slot_reg <= '0;
                end else if (slot_we && (slot_addr == IDX_W'(gi))) begin
                    slot_reg <= slot_data;
                end
            end
            assign samples[gi*DATA_WIDTH +: DATA_WIDTH] = slot_reg;
        end
    endgenerate

    assign result_index    = index_reg;
    assign result_overflow = overflow_reg;
    assign result_timeout  = timeout_reg;

endmodule

// File: tb/tb_frequency_scan_controller.sv
// Bench for frequency_scan_controller: random and directed scan lines against a run-length
// model, with a per-cycle compare of control outputs, sample bus and results.
module tb_frequency_scan_controller;
    localparam int DW      = 8;
    localparam int SQ      = 8;
    localparam int TO      = 16;
    localparam int MINRUN  = 2;
    localparam int RUNMAX  = (1 << DW) - 1;
    localparam logic [DW-1:0] ALL_ONES = '1;
`ifdef FREQ_SCAN_MIN_RUN_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           line_start = 1'b0;
    logic           pixel_valid = 1'b0;
    logic           pixel_value = 1'b0;
    logic           pixel_last = 1'b0;
    logic           recognizer_completed = 1'b0;
    logic [DW-1:0]  recognizer_index = '0;
    logic           result_ready = 1'b0;
    logic           pixel_ready;
    logic [DW*SQ-1:0] samples;
    logic           recognizer_reset;
    logic           result_valid;
    logic [DW-1:0]  result_index;
    logic           result_overflow;
    logic           result_timeout;
    logic           busy;

    frequency_scan_controller #(
        .DATA_WIDTH      (DW),
        .SAMPLES_QUANTITY(SQ),
        .TIMEOUT_CYCLES  (TO),
        .MIN_RUN_LENGTH  (MINRUN)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .line_start          (line_start),
        .pixel_valid         (pixel_valid),
        .pixel_value         (pixel_value),
        .pixel_last          (pixel_last),
        .pixel_ready         (pixel_ready),
        .samples             (samples),
        .recognizer_reset    (recognizer_reset),
        .recognizer_completed(recognizer_completed),
        .recognizer_index    (recognizer_index),
        .result_valid        (result_valid),
        .result_ready        (result_ready),
        .result_index        (result_index),
        .result_overflow     (result_overflow),
        .result_timeout      (result_timeout),
        .busy                (busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Expected outputs for the current cycle, written by the driver just after each rising edge.
    bit            chk_en = 1'b0;
    bit            chk_data = 1'b0;
    bit            chk_res = 1'b0;
    logic          exp_pready, exp_busy, exp_rreset, exp_rvalid;
    logic [DW-1:0] exp_slots [SQ];
    logic [DW-1:0] exp_index;
    logic          exp_ovf, exp_to;

    bit            pix_q[$];
    logic [DW-1:0] m_slots [SQ];
    logic          m_ovf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h, required %0h", name, $time, act, req);
        end
    endtask

    // Model: split the line into runs, then place them into slots.
    task automatic model_line();
        int runs[$];
        int n;
        for (int i = 0; i < pix_q.size(); i++) begin
            if (i == 0 || pix_q[i] != pix_q[i-1]) runs.push_back(1);
            else if (runs[runs.size()-1] < RUNMAX) runs[runs.size()-1] = runs[runs.size()-1] + 1;
        end
        n = 0;
        m_ovf = 1'b0;
        for (int s = 0; s < SQ; s++) m_slots[s] = '0;
        foreach (runs[r]) begin
            if (FILT && runs[r] < MINRUN && n > 0) begin
                int sum;
                sum = int'(m_slots[n-1]) + runs[r];
                m_slots[n-1] = DW'((sum > RUNMAX) ? RUNMAX : sum);
            end else if (n < SQ) begin
                m_slots[n] = DW'(runs[r]);
                n++;
            end else begin
                m_ovf = 1'b1;
            end
        end
    endtask

    task automatic pin_slots(input int req[SQ], input bit ovf);
        model_line();
        for (int i = 0; i < SQ; i++) check($sformatf("model_slot%0d", i), m_slots[i], req[i]);
        check("model_overflow", m_ovf, ovf);
    endtask

    task automatic load_str(input string s);
        pix_q.delete();
        for (int i = 0; i < s.len(); i++) pix_q.push_back(s[i] == "1");
    endtask

    task automatic set_exp(input logic pr, input logic b, input logic rr, input logic rv);
        chk_en = 1'b1;
        exp_pready = pr;
        exp_busy = b;
        exp_rreset = rr;
        exp_rvalid = rv;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values();
        check("rst_pixel_ready", pixel_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_recognizer_reset", recognizer_reset, 1'b1);
        check("rst_result_valid", result_valid, 1'b0);
        check("rst_result_index", result_index, 0);
        check("rst_result_overflow", result_overflow, 1'b0);
        check("rst_result_timeout", result_timeout, 1'b0);
        for (int i = 0; i < SQ; i++) check($sformatf("rst_slot%0d", i), samples[i*DW +: DW], 0);
    endtask

    task automatic idle_cycle();
        tick();
        line_start = 1'b0;
        pixel_valid = 1'($urandom);
        pixel_value = 1'($urandom);
        pixel_last = 1'($urandom);
        recognizer_completed = 1'b0;
        result_ready = 1'($urandom);
        chk_data = 1'b0;
        chk_res = 1'b0;
        set_exp(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    // Drive one full line; d = RECOGNIZE cycle in which the stub completes (>= TO: never).
    task automatic run_line(input int d, input logic [DW-1:0] idx, input int ready_delay, input int gap_pct);
        int n_rec;
        model_line();
        tick();
        line_start = 1'b1;
        pixel_valid = 1'($urandom);
        pixel_value = 1'($urandom);
        pixel_last = 1'b0;
        result_ready = 1'b0;
        recognizer_completed = 1'b0;
        chk_data = 1'b0;
        chk_res = 1'b0;
        set_exp(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < pix_q.size(); i++) begin
            int gaps;
            gaps = ($urandom_range(99) < gap_pct) ? $urandom_range(3, 1) : 0;
            for (int g = 0; g < gaps; g++) begin
                tick();
                line_start = 1'($urandom);
                pixel_valid = 1'b0;
                pixel_value = 1'($urandom);
                pixel_last = 1'($urandom);
                set_exp(1'b1, 1'b1, 1'b1, 1'b0);
            end
            tick();
            line_start = 1'($urandom);
            pixel_valid = 1'b1;
            pixel_value = pix_q[i];
            pixel_last = (i == pix_q.size() - 1);
            set_exp(1'b1, 1'b1, 1'b1, 1'b0);
        end
        tick();
        line_start = 1'($urandom);
        pixel_valid = 1'($urandom);
        pixel_last = 1'($urandom);
        set_exp(1'b0, 1'b1, 1'b1, 1'b0);
        exp_slots = m_slots;
        exp_ovf = m_ovf;
        exp_index = (d < TO) ? idx : ALL_ONES;
        exp_to = (d >= TO);
        n_rec = (d < TO) ? d + 1 : TO;
        for (int c = 0; c < n_rec; c++) begin
            tick();
            line_start = 1'($urandom);
            pixel_valid = 1'($urandom);
            recognizer_completed = (c == d);
            recognizer_index = (c == d) ? idx : DW'($urandom);
            chk_data = 1'b1;
            set_exp(1'b0, 1'b1, 1'b0, 1'b0);
        end
        for (int r = 0; r <= ready_delay; r++) begin
            tick();
            line_start = 1'($urandom);
            recognizer_completed = 1'($urandom);
            recognizer_index = DW'($urandom);
            result_ready = (r == ready_delay);
            chk_res = 1'b1;
            set_exp(1'b0, 1'b1, 1'b1, 1'b1);
        end
        idle_cycle();
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("pixel_ready", pixel_ready, exp_pready);
            check("busy", busy, exp_busy);
            check("recognizer_reset", recognizer_reset, exp_rreset);
            check("result_valid", result_valid, exp_rvalid);
            if (chk_data) begin
                for (int i = 0; i < SQ; i++)
                    check($sformatf("slot%0d", i), samples[i*DW +: DW], exp_slots[i]);
            end
            if (chk_res) begin
                check("result_index", result_index, exp_index);
                check("result_overflow", result_overflow, exp_ovf);
                check("result_timeout", result_timeout, exp_to);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog at %0t: simulation still running, required to finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1 reset = 1'b0;
        #1 check_reset_values();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        idle_cycle();

        // 111 00 11 00 1 000, stub completes in the 5th RECOGNIZE cycle with index 4
        load_str("1110011001000");
`ifdef FREQ_SCAN_MIN_RUN_FILTER_EN
        pin_slots('{3, 2, 2, 3, 3, 0, 0, 0}, 1'b0);
`else
        pin_slots('{3, 2, 2, 2, 1, 3, 0, 0}, 1'b0);
`endif
        run_line(4, 8'd4, 0, 0);

        // 300 identical pixels saturate the first run
        pix_q.delete();
        for (int i = 0; i < 300; i++) pix_q.push_back(1'b1);
        pin_slots('{255, 0, 0, 0, 0, 0, 0, 0}, 1'b0);
        run_line(2, 8'h2A, 1, 20);

        // ten single-pixel runs against eight slots
        load_str("1010101010");
`ifdef FREQ_SCAN_MIN_RUN_FILTER_EN
        pin_slots('{10, 0, 0, 0, 0, 0, 0, 0}, 1'b0);
`else
        pin_slots('{1, 1, 1, 1, 1, 1, 1, 1}, 1'b1);
`endif
        run_line(0, 8'h11, 0, 0);

        // timeout, then completion in the last allowed cycle
        load_str("0011");
        run_line(1000, 8'h55, 0, 0);
        run_line(TO - 1, 8'h33, 0, 0);

        // consumer stalls for 10 cycles
        load_str("0110001");
        run_line(5, 8'h77, 10, 30);

        load_str("1110111");
`ifdef FREQ_SCAN_MIN_RUN_FILTER_EN
        pin_slots('{4, 3, 0, 0, 0, 0, 0, 0}, 1'b0);
`else
        pin_slots('{3, 1, 3, 0, 0, 0, 0, 0}, 1'b0);
`endif
        run_line(3, 8'h09, 2, 0);

        load_str("0");
        pin_slots('{1, 0, 0, 0, 0, 0, 0, 0}, 1'b0);
        run_line(1, 8'hC3, 0, 0);

        // asynchronous reset in the middle of a line
        load_str("11001");
        tick();
        line_start = 1'b1;
        pixel_valid = 1'b0;
        set_exp(1'b0, 1'b0, 1'b1, 1'b0);
        foreach (pix_q[i]) begin
            tick();
            line_start = 1'b0;
            pixel_valid = 1'b1;
            pixel_value = pix_q[i];
            pixel_last = 1'b0;
            set_exp(1'b1, 1'b1, 1'b1, 1'b0);
        end
        tick();
        pixel_valid = 1'b0;
        set_exp(1'b1, 1'b1, 1'b1, 1'b0);
        check("pre_reset_slot0", samples[0 +: DW], 2);
        check("pre_reset_slot1", samples[DW +: DW], 2);
        @(negedge clk);
        chk_en = 1'b0;
        #2 reset = 1'b0;
        #1 check_reset_values();
        @(negedge clk);
        #1 reset = 1'b1;
        idle_cycle();

        // random lines
        for (int t = 0; t < 40; t++) begin
            int len;
            bit v;
            len = $urandom_range(40, 1);
            v = 1'($urandom);
            pix_q.delete();
            while (pix_q.size() < len) begin
                int rl;
                rl = $urandom_range(4, 1);
                for (int k = 0; k < rl; k++) if (pix_q.size() < len) pix_q.push_back(v);
                v = !v;
            end
            run_line($urandom_range(TO + 4, 0), DW'($urandom), $urandom_range(3, 0), 30);
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/frequency_scan_controller.md
Name: frequency_scan_controller

Overview:
- Sequencer for frequency_pattern_recognizer.
- Takes a binarized pixel stream for one scan line and converts it into run lengths, e.g. 3-2-2-2-1-3.
- Loads the run lengths into a sample buffer, releases the recognizer from reset, then waits for scanning_completed or a timeout.
- Returns the captured frequency_jump_index to the downstream consumer over a valid/ready handshake.

Parameters:
- DATA_WIDTH, 8, width of each run-length sample and of the jump index.
- SAMPLES_QUANTITY, 25, number of run-length slots presented to the recognizer.
- TIMEOUT_CYCLES, 1024, maximum cycles spent in RECOGNIZE before abort.
- MIN_RUN_LENGTH, 2, runs shorter than this are merged (optional feature only).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- line_start  in  1  pulse; starts a new scan line (accepted in IDLE only).
- pixel_valid  in  1  pixel_value valid.
- pixel_value  in  1  binarized pixel.
- pixel_last  in  1  qualifies the last pixel of the line.
- pixel_ready  out  1  high only in COLLECT.
- samples  out  DATA_WIDTH*SAMPLES_QUANTITY  flat sample bus to the recognizer data input; slot i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- recognizer_reset  out  1  active-high reset to the recognizer.
- recognizer_completed  in  1  recognizer scanning_completed.
- recognizer_index  in  DATA_WIDTH  recognizer frequency_jump_index.
- result_valid  out  1  result available.
- result_ready  in  1  consumer accepts the result.
- result_index  out  DATA_WIDTH  captured jump index.
- result_overflow  out  1  the line produced more than SAMPLES_QUANTITY runs.
- result_timeout  out  1  the recognizer did not complete in time.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - All sample slots, run counter, slot index, result_* and pixel_ready go to 0.
  - recognizer_reset goes to 1.
  - A mid-operation reset discards the line and any pending result.
- States: IDLE, COLLECT, FLUSH, RECOGNIZE, DONE.
- IDLE:
  - On line_start: clear all slots, set slot index and run length to 0, clear result flags, go to COLLECT next cycle.
  - pixel_valid is ignored in IDLE.
  - line_start is ignored in every state except IDLE.
- COLLECT: a pixel is accepted when pixel_valid and pixel_ready are both high.
  - First pixel: run length = 1 and current colour = pixel_value.
  - Same colour: run length increments, saturating at 2^DATA_WIDTH-1.
  - Colour change: the run is written to slot[slot index] if slot index < SAMPLES_QUANTITY, otherwise overflow is set and the run is dropped. Slot index increments, saturating at SAMPLES_QUANTITY. Run length = 1 and current colour is updated.
  - If the accepted pixel has pixel_last set, the pixel is processed first and the next state is FLUSH.
- FLUSH (one cycle): the final run is written under the same overflow rule; go to RECOGNIZE.
- RECOGNIZE:
  - recognizer_reset = 0 and the samples bus is held stable; a cycle counter counts up from 0.
  - If recognizer_completed = 1: capture recognizer_index, go to DONE.
  - Else, if the counter reaches TIMEOUT_CYCLES-1: result_index = all ones, result_timeout = 1, go to DONE.
  - Completion and timeout in the same cycle: completion wins.
- DONE:
  - recognizer_reset = 1 and result_valid = 1.
  - result_index, result_overflow and result_timeout are held until result_valid and result_ready are both high.
  - The cycle after the handshake, return to IDLE.
- Latency:
  - line_start in cycle N makes pixel_ready = 1 in cycle N+1.
  - pixel_last accepted in cycle N gives FLUSH in N+1 and recognizer_reset = 0 from N+2.
  - result_valid rises the cycle after completion is sampled.
- Unused slots read 0.
- A single-pixel line yields slot0 = 1.

Optional Feature:
- Macro: FREQ_SCAN_MIN_RUN_FILTER_EN.
- When defined: a closed run with length < MIN_RUN_LENGTH is not stored as a new slot when at least one slot is already written. It is added, saturating, to the last written slot, and slot index does not advance. The first run of a line is always stored.
- When undefined: every run is stored, and MIN_RUN_LENGTH is unused.

Test Plan:
- Line 111 00 11 00 1 000 (pixel_last on the final 0), recognizer stub completes 4 cycles into RECOGNIZE with index 4 -> slots 3,2,2,2,1,3 and slots 6..24 = 0; recognizer_reset low exactly 2 cycles after pixel_last; result_index = 4, result_valid = 1, overflow = 0, timeout = 0.
- 300 identical pixels, DATA_WIDTH = 8 -> slot0 = 255, slot1 = 0, no overflow.
- SAMPLES_QUANTITY = 4, alternating 6 pixels 101010 -> slots 1,1,1,1, result_overflow = 1.
- TIMEOUT_CYCLES = 16, stub never completes -> DONE after 16 RECOGNIZE cycles, result_index = 0xFF, result_timeout = 1; completion arriving in the 16th cycle instead gives timeout = 0 and the stub index.
- result_ready held low for 10 cycles -> result_valid and outputs stable; line_start ignored; IDLE one cycle after result_ready = 1.
- reset driven low mid-COLLECT, no clock edge -> pixel_ready = 0, busy = 0, recognizer_reset = 1 and slots = 0 immediately.
- With FREQ_SCAN_MIN_RUN_FILTER_EN, line 1110111 -> slot0 = 4, slot1 = 3.
